// File: rtl/decade_chain_ctrl.sv
// Run/pause/clear controller for a chain of BCD decade digits.
// A prescaler turns clk into count ticks; carries ripple digit to digit and counting stops on a programmable target.
module decade_chain_ctrl #(
   parameter int unsigned NDIG     = 2,
   parameter int unsigned PRESCALE = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              stop,
   input  logic              clear,
   input  logic [4*NDIG-1:0] target,
   output logic [4*NDIG-1:0] cnt,
   output logic              tick,
   output logic              running,
   output logic              done,
   output logic              wrap
);

   localparam int unsigned CW = 4 * NDIG;
   localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PW-1:0] PLAST = PW'(PRESCALE - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t        state;
   logic [PW-1:0] presc;
   logic [CW-1:0] tgt_q;
   logic [CW-1:0] cnt_inc;
   logic          all_nine;
   logic          go;

   // stop always beats start
   assign go      = start & ~stop;
   assign running = (state == RUN);

   // Ripple-carry BCD increment: digit i steps only when every lower digit is 9
   always_comb begin
      cnt_inc  = cnt;
      all_nine = 1'b1;
      for (int i = 0; i < int'(NDIG); i++) begin
         if (all_nine) begin
            cnt_inc[4*i +: 4] = (cnt[4*i +: 4] == 4'd9) ? 4'd0 : cnt[4*i +: 4] + 4'd1;
         end
         all_nine = all_nine & (cnt[4*i +: 4] == 4'd9);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         cnt   <= '0;
         presc <= '0;
         tgt_q <= '0;
         tick  <= 1'b0;
         done  <= 1'b0;
         wrap  <= 1'b0;
      end else begin
         tick <= 1'b0;
         done <= 1'b0;
         wrap <= 1'b0;
         if (clear) begin
            state <= IDLE;
            cnt   <= '0;
            presc <= '0;
         end else begin
            case (state)
               IDLE: begin
                  if (go) begin
                     state <= RUN;
                     tgt_q <= target;
                  end
               end
               RUN: begin
                  if (stop) begin
                     state <= PAUSE;
                  end else if (presc == PLAST) begin
                     // count step; hitting the target parks the counter in DONE
                     presc <= '0;
                     tick  <= 1'b1;
                     cnt   <= cnt_inc;
                     wrap  <= all_nine;
                     if (cnt_inc == tgt_q) begin
                        done  <= 1'b1;
                        state <= DONE;
                     end
                  end else begin
                     presc <= presc + PW'(1);
                  end
               end
               PAUSE: begin
                  if (go) state <= RUN;
               end
               DONE: begin
                  if (go) begin
                     state <= RUN;
                     tgt_q <= target;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_decade_chain_ctrl.sv
// Self-checking bench for decade_chain_ctrl: directed scenarios plus randomized commands
// against an integer-valued reference model.
module tb_decade_chain_ctrl;

   localparam int unsigned NDIG     = 2;
   localparam int unsigned PRESCALE = 4;
   localparam int unsigned CW       = 4 * NDIG;
   localparam int          MAXV     = 10 ** NDIG;
   localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_DONE = 3;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          start, stop, clear;
   logic [CW-1:0] target;
   logic [CW-1:0] cnt;
   logic          tick, running, done, wrap;

   int checks   = 0;
   int failures = 0;

   // reference model: count kept as a plain integer, phase as cycles since last tick
   int            m_val, m_phase, m_mode;
   logic [CW-1:0] m_tgt;
   logic          m_tick, m_done, m_wrap;

   decade_chain_ctrl #(.NDIG(NDIG), .PRESCALE(PRESCALE)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .clear(clear),
      .target(target), .cnt(cnt), .tick(tick), .running(running), .done(done), .wrap(wrap)
   );

   always #5 clk = ~clk;

   function automatic logic [CW-1:0] to_bcd(input int v);
      logic [CW-1:0] r;
      int x;
      x = v;
      r = '0;
      for (int i = 0; i < int'(NDIG); i++) begin
         r[4*i +: 4] = 4'(x % 10);
         x = x / 10;
      end
      return r;
   endfunction

   task automatic model_reset();
      m_val = 0; m_phase = 0; m_mode = M_IDLE; m_tgt = '0;
      m_tick = 1'b0; m_done = 1'b0; m_wrap = 1'b0;
   endtask

   task automatic model_edge(input logic s, input logic p, input logic c, input logic [CW-1:0] t);
      m_tick = 1'b0; m_done = 1'b0; m_wrap = 1'b0;
      if (c) begin
         m_mode = M_IDLE; m_val = 0; m_phase = 0;
      end else if (m_mode == M_RUN) begin
         if (p) m_mode = M_PAUSE;
         else begin
            m_phase++;
            if (m_phase == int'(PRESCALE)) begin
               m_phase = 0;
               m_tick  = 1'b1;
               m_val   = (m_val + 1) % MAXV;
               m_wrap  = (m_val == 0);
               if (to_bcd(m_val) == m_tgt) begin
                  m_done = 1'b1;
                  m_mode = M_DONE;
               end
            end
         end
      end else if (s && !p) begin
         if (m_mode != M_PAUSE) m_tgt = t;
         m_mode = M_RUN;
      end
   endtask

   // one clock: drive on negedge, update model at posedge, leave time at posedge+1
   task automatic step(input logic s, input logic p, input logic c, input logic [CW-1:0] t);
      @(negedge clk);
      start = s; stop = p; clear = c; target = t;
      @(posedge clk);
      model_edge(s, p, c, t);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; start = 1'b0; stop = 1'b0; clear = 1'b0; target = '0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({cnt, tick, running, done, wrap} !== {CW'(0), 4'b0000}) begin
         failures++;
         $display("FAIL reset: cnt=%h tick=%b run=%b done=%b wrap=%b, expected all zero",
                  cnt, tick, running, done, wrap);
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_target_05();
      int ndone = 0;
      bit hit = 0;
      step(1'b1, 1'b0, 1'b0, 8'h05);
      for (int k = 0; k < 200 && !hit; k++) begin
         step(1'b0, 1'b0, 1'b0, 8'h00);
         checks++;
         if ({cnt, tick, done, wrap, running} !== {to_bcd(m_val), m_tick, m_done, m_wrap, m_mode == M_RUN}) begin
            failures++;
            $display("FAIL target_05 k=%0d: cnt=%h tick=%b done=%b wrap=%b run=%b expected %h %b %b %b %b",
                     k, cnt, tick, done, wrap, running, to_bcd(m_val), m_tick, m_done, m_wrap, m_mode == M_RUN);
         end
         if (done) ndone++;
         hit = m_done;
      end
      repeat (3) step(1'b0, 1'b0, 1'b0, 8'h00);
      checks++;
      if ({ndone, cnt, running, done} !== {32'd1, 8'h05, 1'b0, 1'b0}) begin
         failures++;
         $display("FAIL target_05_end: done_pulses=%0d cnt=%h run=%b done=%b expected 1 05 0 0",
                  ndone, cnt, running, done);
      end
   endtask

   task automatic test_carry_99();
      int nwrap = 0;
      bit hit = 0;
      step(1'b1, 1'b0, 1'b0, 8'h99);
      for (int k = 0; k < 1000 && !hit; k++) begin
         step(1'b0, 1'b0, 1'b0, 8'h00);
         checks++;
         if ({cnt, tick, done, wrap, running} !== {to_bcd(m_val), m_tick, m_done, m_wrap, m_mode == M_RUN}) begin
            failures++;
            $display("FAIL carry_99 k=%0d: cnt=%h tick=%b done=%b wrap=%b run=%b expected %h %b %b %b %b",
                     k, cnt, tick, done, wrap, running, to_bcd(m_val), m_tick, m_done, m_wrap, m_mode == M_RUN);
         end
         if (wrap) nwrap++;
         hit = m_done;
      end
      checks++;
      if ({cnt, nwrap, running} !== {8'h99, 32'd0, 1'b0}) begin
         failures++;
         $display("FAIL carry_99_end: cnt=%h wraps=%0d run=%b expected 99 0 0", cnt, nwrap, running);
      end
   endtask

   task automatic test_wrap_zero();
      bit hit = 0;
      logic [2:0] seen = 3'b000;
      logic [CW-1:0] seen_cnt = '1;
      step(1'b1, 1'b0, 1'b0, 8'h00);
      for (int k = 0; k < 100 && !hit; k++) begin
         step(1'b0, 1'b0, 1'b0, 8'h00);
         checks++;
         if ({cnt, tick, done, wrap, running} !== {to_bcd(m_val), m_tick, m_done, m_wrap, m_mode == M_RUN}) begin
            failures++;
            $display("FAIL wrap_zero k=%0d: cnt=%h tick=%b done=%b wrap=%b run=%b expected %h %b %b %b %b",
                     k, cnt, tick, done, wrap, running, to_bcd(m_val), m_tick, m_done, m_wrap, m_mode == M_RUN);
         end
         hit = m_done;
         if (hit) begin
            seen = {tick, done, wrap};
            seen_cnt = cnt;
         end
      end
      checks++;
      if ({seen, seen_cnt} !== {3'b111, 8'h00}) begin
         failures++;
         $display("FAIL wrap_zero_end: tick/done/wrap=%b cnt=%h expected 111 00", seen, seen_cnt);
      end
   endtask

   task automatic test_pause();
      bit at3 = 0;
      int extra;
      logic [CW-1:0] held;
      step(1'b0, 1'b0, 1'b1, 8'h00);
      step(1'b1, 1'b0, 1'b0, 8'h99);
      for (int k = 0; k < 100 && !at3; k++) begin
         step(1'b0, 1'b0, 1'b0, 8'h00);
         at3 = (to_bcd(m_val) == 8'h03);
      end
      extra = $urandom_range(0, PRESCALE - 2);
      repeat (extra) step(1'b0, 1'b0, 1'b0, 8'h00);
      held = cnt;
      for (int k = 0; k < 20; k++) begin
         step(k[0], 1'b1, 1'b0, 8'h00);
         checks++;
         if ({cnt, tick, running} !== {held, 1'b0, 1'b0} || held !== 8'h03) begin
            failures++;
            $display("FAIL pause k=%0d: cnt=%h tick=%b run=%b expected 03 0 0", k, cnt, tick, running);
         end
      end
      step(1'b1, 1'b0, 1'b0, 8'h00);
      for (int k = 0; k < 12; k++) begin
         step(1'b0, 1'b0, 1'b0, 8'h00);
         checks++;
         if ({cnt, tick, done, wrap, running} !== {to_bcd(m_val), m_tick, m_done, m_wrap, m_mode == M_RUN}) begin
            failures++;
            $display("FAIL resume k=%0d: cnt=%h tick=%b done=%b wrap=%b run=%b expected %h %b %b %b %b",
                     k, cnt, tick, done, wrap, running, to_bcd(m_val), m_tick, m_done, m_wrap, m_mode == M_RUN);
         end
      end
   endtask

   task automatic test_clear();
      bit at7 = 0;
      bit hit = 0;
      step(1'b0, 1'b0, 1'b1, 8'h00);
      step(1'b1, 1'b0, 1'b0, 8'h99);
      for (int k = 0; k < 100 && !at7; k++) begin
         step(1'b0, 1'b0, 1'b0, 8'h00);
         at7 = (to_bcd(m_val) == 8'h07);
      end
      step(1'b1, 1'b0, 1'b1, 8'h55);
      checks++;
      if ({cnt, tick, running} !== {8'h00, 1'b0, 1'b0}) begin
         failures++;
         $display("FAIL clear: cnt=%h tick=%b run=%b expected 00 0 0", cnt, tick, running);
      end
      step(1'b1, 1'b0, 1'b0, 8'h02);
      for (int k = 0; k < 50 && !hit; k++) begin
         step(1'b0, 1'b0, 1'b0, 8'h00);
         hit = m_done;
      end
      checks++;
      if ({cnt, done, running} !== {8'h02, 1'b1, 1'b0}) begin
         failures++;
         $display("FAIL clear_reload: cnt=%h done=%b run=%b expected 02 1 0", cnt, done, running);
      end
   endtask

   task automatic test_async_reset();
      step(1'b0, 1'b0, 1'b1, 8'h00);
      step(1'b1, 1'b0, 1'b0, 8'h99);
      repeat (6) step(1'b0, 1'b0, 1'b0, 8'h00);
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      checks++;
      if ({cnt, tick, running, done, wrap} !== {CW'(0), 4'b0000}) begin
         failures++;
         $display("FAIL async_reset: cnt=%h tick=%b run=%b done=%b wrap=%b expected all zero",
                  cnt, tick, running, done, wrap);
      end
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 8; k++) begin
         step(1'b0, 1'b0, 1'b0, 8'h00);
         checks++;
         if ({cnt, tick, running} !== {8'h00, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL post_reset_idle k=%0d: cnt=%h tick=%b run=%b expected 00 0 0", k, cnt, tick, running);
         end
      end
      step(1'b1, 1'b0, 1'b0, 8'h99);
      for (int k = 0; k < 10; k++) begin
         step(1'b0, 1'b0, 1'b0, 8'h00);
         checks++;
         if ({cnt, tick, running} !== {to_bcd(m_val), m_tick, m_mode == M_RUN}) begin
            failures++;
            $display("FAIL post_reset_run k=%0d: cnt=%h tick=%b run=%b expected %h %b %b",
                     k, cnt, tick, running, to_bcd(m_val), m_tick, m_mode == M_RUN);
         end
      end
   endtask

   task automatic test_random();
      int r;
      logic s, p, c;
      logic [CW-1:0] t;
      for (int k = 0; k < 3000; k++) begin
         r = $urandom_range(0, 99);
         c = (r < 2);
         p = (r >= 2 && r < 7);
         s = (r >= 7 && r < 22);
         if ($urandom_range(0, 7) == 0) t = CW'($urandom);
         else t = to_bcd($urandom_range(0, MAXV - 1));
         step(s, p, c, t);
         checks++;
         if ({cnt, tick, done, wrap, running} !== {to_bcd(m_val), m_tick, m_done, m_wrap, m_mode == M_RUN}) begin
            failures++;
            $display("FAIL random k=%0d: cnt=%h tick=%b done=%b wrap=%b run=%b expected %h %b %b %b %b",
                     k, cnt, tick, done, wrap, running, to_bcd(m_val), m_tick, m_done, m_wrap, m_mode == M_RUN);
         end
      end
   endtask

   initial begin
      test_reset();
      test_target_05();
      test_carry_99();
      test_wrap_zero();
      test_pause();
      test_clear();
      test_async_reset();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
